// File: rtl/fxp_pkg.sv
// Shared fixed-point types and constants for the transform pipeline:
// Q8.8 element type, 4x4 row-major matrix type, Q8.8 limits and the
// matrix multiplier controller state encoding.
package fxp_pkg;

    // Signed Q8.8 element
    typedef logic signed [15:0] fxp_t;

    // 4x4 matrix, row-major, element (r,c) at index r*4+c
    typedef logic [15:0][15:0] mat4_t;

    localparam logic [15:0] FXP_ONE = 16'h0100;
    localparam logic [15:0] FXP_MAX = 16'h7FFF;
    localparam logic [15:0] FXP_MIN = 16'h8000;

    // Sequential multiplier controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } mm_state_t;

    // Row-major flat index of element (row, col) in a 4x4 matrix
    function automatic logic [3:0] mat_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Fixed-point multiply-accumulate slice.
// acc_out = clr ? 0 : acc_in + a*b  (Q(2*DW-2F).2F accumulator, two guard bits)
// q/ovf   = acc_in narrowed back to Q8.8 by floor truncation of FRAC_BITS.
// Build option MATMUL_SATURATE_EN: out-of-range values clamp to the Q8.8
// limits; otherwise the truncated bits are passed through (wrap). The
// overflow flag is produced the same way in both builds.
module fxp_mac #(
    parameter int DW        = 16,
    parameter int FRAC_BITS = 8,
    parameter int AW        = 2 * DW + 2
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    input  logic signed [AW-1:0] i_acc_in,
    input  logic                 i_clr,
    output logic signed [AW-1:0] o_acc_out,
    output logic        [DW-1:0] o_q,
    output logic                 o_ovf
);

    localparam int HI = AW - 1;
    localparam int LO = FRAC_BITS + DW - 1;

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_sum;
    logic        [HI-LO:0]  w_upper;
    logic        [DW-1:0]   w_trunc;

    assign w_prod  = i_a * i_b;
    assign w_sum   = i_acc_in + AW'(w_prod);
    assign w_trunc = i_acc_in[FRAC_BITS+DW-1:FRAC_BITS];

    // Bits above the Q8.8 sign bit must all match the sign to be in range
    assign w_upper = i_acc_in[HI:LO];

    // Accumulate or clear, and narrow the current accumulator to Q8.8
    always_comb begin
        o_acc_out = i_clr ? '0 : w_sum;
        o_ovf     = !((&w_upper) || !(|w_upper));
        o_q       = w_trunc;
`ifdef MATMUL_SATURATE_EN
        if (o_ovf) begin
            o_q = i_acc_in[HI] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential 4x4 Q8.8 matrix multiplier, R = A x B, one MAC per cycle.
// Each result element takes 4 MAC cycles and 1 writeback cycle; a whole
// product completes 80 cycles after the accepted start, followed by a
// one-cycle done pulse. Operands are captured at start.
// Build option MATMUL_SATURATE_EN selects clamping of out-of-range
// elements (see fxp_mac); default is two's-complement wrap.
module matrix_mult_seq
    import fxp_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int DW        = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [15:0][DW-1:0] mat_a,
    input  logic [15:0][DW-1:0] mat_b,
    output logic [15:0][DW-1:0] result,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int AW = 2 * DW + 2;

    mm_state_t r_state;
    mm_state_t w_state_nxt;

    logic [15:0][DW-1:0]  r_a;
    logic [15:0][DW-1:0]  r_b;
    logic [15:0][DW-1:0]  r_result;
    logic signed [AW-1:0] r_acc;
    logic [1:0]           r_i;
    logic [1:0]           r_j;
    logic [1:0]           r_k;
    logic                 r_ovf;

    logic signed [AW-1:0] w_acc_nxt;
    logic [DW-1:0]        w_q;
    logic                 w_ovf;
    logic                 w_clr;
    logic [3:0]           w_a_idx;
    logic [3:0]           w_b_idx;
    logic [3:0]           w_r_idx;

    // a(i,k) * b(k,j) feeds the MAC, writeback goes to r(i,j)
    assign w_a_idx = mat_idx(r_i, r_k);
    assign w_b_idx = mat_idx(r_k, r_j);
    assign w_r_idx = mat_idx(r_i, r_j);

    // Accumulator only runs in MAC; every other state holds it at zero,
    // which also gives the clear after writeback and before a new product
    assign w_clr = (r_state != ST_MAC);

    fxp_mac #(
        .DW        (DW),
        .FRAC_BITS (FRAC_BITS),
        .AW        (AW)
    ) u_mac (
        .i_a       (r_a[w_a_idx]),
        .i_b       (r_b[w_b_idx]),
        .i_acc_in  (r_acc),
        .i_clr     (w_clr),
        .o_acc_out (w_acc_nxt),
        .o_q       (w_q),
        .o_ovf     (w_ovf)
    );

    // Controller state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                busy = 1'b1;
                if (r_k == 2'd3) w_state_nxt = ST_WB;
            end
            ST_WB: begin
                busy = 1'b1;
                if (w_r_idx == 4'd15) w_state_nxt = ST_DONE;
                else                  w_state_nxt = ST_MAC;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Accumulator register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_acc <= '0;
        else       r_acc <= w_acc_nxt;
    end

    // Operand capture, loop indices, element writeback and sticky overflow
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= mat_a;
                        r_b   <= mat_b;
                        r_ovf <= 1'b0;
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                    end
                end
                ST_MAC: begin
                    r_k <= r_k + 2'd1;
                end
                ST_WB: begin
                    r_result[w_r_idx] <= w_q;
                    if (w_ovf) r_ovf <= 1'b1;
                    r_k <= '0;
                    r_j <= r_j + 2'd1;
                    if (r_j == 2'd3) r_i <= r_i + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: directed vector table, random
// products against a plain-arithmetic reference, start-while-busy and
// reset-mid-operation sequences.
module tb_matrix_mult_seq;
    import fxp_pkg::*;

    logic  Clk = 1'b0;
    logic  Reset;
    logic  start;
    mat4_t mat_a, mat_b, result;
    logic  busy, done, overflow;

    int checks = 0;
    int errors = 0;

    matrix_mult_seq #(.FRAC_BITS(8), .DW(16)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .mat_a(mat_a), .mat_b(mat_b),
        .result(result), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string name;
        mat4_t a;
        mat4_t b;
        mat4_t r;
        bit    ov;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Reference: sum of exact integer products, floor-divide by 2^8, then
    // range check against the signed 16-bit Q8.8 range
    function automatic void ref_mul(input mat4_t a, input mat4_t b, output mat4_t r, output bit ov);
        longint s, t;
        ov = 1'b0;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'($signed(a[i*4+k])) * longint'($signed(b[k*4+j]));
                t = s >>> 8;
                if (t > 32767 || t < -32768) begin
                    ov = 1'b1;
`ifdef MATMUL_SATURATE_EN
                    r[i*4+j] = (t > 0) ? 16'h7FFF : 16'h8000;
`else
                    r[i*4+j] = t[15:0];
`endif
                end else begin
                    r[i*4+j] = t[15:0];
                end
            end
        end
    endfunction

    function automatic mat4_t ident();
        mat4_t m = '0;
        for (int d = 0; d < 4; d++) m[d*5] = FXP_ONE;
        return m;
    endfunction

    // One-cycle start pulse accepted at the following posedge (E0); the
    // input operands are scrambled afterwards to exercise the capture
    task automatic do_start(input mat4_t a, input mat4_t b);
        @(negedge Clk);
        mat_a = a; mat_b = b; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int e = 0; e < 16; e++) begin
            mat_a[e] = 16'($urandom);
            mat_b[e] = 16'($urandom);
        end
    endtask

    // Count edges after E0 until done is seen; optionally pulse start
    // (with other operands) so it is sampled at edge poke+1
    task automatic run_to_done(input int poke, input mat4_t pa, input mat4_t pb,
                               output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clk); #1;
            if (n == poke) begin
                start = 1'b1; mat_a = pa; mat_b = pb;
            end else if (n == poke + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    // Full product with timing, result and overflow checks
    task automatic run_product(input string nm, input mat4_t a, input mat4_t b,
                               input mat4_t er, input bit eov);
        int lat;
        bit bok;
        do_start(a, b);
        chk({nm, " busy_after_start"}, 256'(busy), 256'(1));
        run_to_done(-10, '0, '0, lat, bok);
        chk({nm, " done_latency"}, 256'(lat), 256'(80));
        chk({nm, " busy_window"}, 256'(bok), 256'(1));
        chk({nm, " busy_low_in_done"}, 256'(busy), 256'(0));
        chk({nm, " result"}, result, er);
        chk({nm, " overflow"}, 256'(overflow), 256'(eov));
        @(posedge Clk); #1;
        chk({nm, " done_one_cycle"}, 256'(done), 256'(0));
    endtask

    initial begin : main
        mat4_t ea, eb, er, m7f;
        bit    eov;
        int    lat;
        bit    bok;
        bit    extra_done;

        // Directed vector table
        tv[0].name = "identity";
        tv[0].a = ident(); tv[0].b = ident(); tv[0].r = ident(); tv[0].ov = 1'b0;

        tv[1].name = "translation";
        tv[1].a = ident(); tv[1].a[3] = 16'hFE00; tv[1].a[7] = 16'h0380; tv[1].a[11] = 16'h0040;
        tv[1].b = ident(); tv[1].r = tv[1].a; tv[1].ov = 1'b0;

        tv[2].name = "neg_trunc";
        tv[2].a = '0; tv[2].a[0] = 16'hFF80;
        tv[2].b = '0; tv[2].b[0] = 16'h0080;
        tv[2].r = '0; tv[2].r[0] = 16'hFFC0; tv[2].ov = 1'b0;

        tv[3].name = "odd_trunc";
        tv[3].a = '0; tv[3].a[0] = 16'hFFFF;
        tv[3].b = '0; tv[3].b[0] = 16'h0080;
        tv[3].r = '0; tv[3].r[0] = 16'hFFFF; tv[3].ov = 1'b0;

        for (int e = 0; e < 16; e++) m7f[e] = 16'h7F00;
        tv[4].name = "overflow";
        tv[4].a = m7f; tv[4].b = m7f; tv[4].ov = 1'b1;
        for (int e = 0; e < 16; e++) begin
`ifdef MATMUL_SATURATE_EN
            tv[4].r[e] = 16'h7FFF;
`else
            tv[4].r[e] = 16'h0400;
`endif
        end

        // Reset state
        Reset = 1'b1; start = 1'b0; mat_a = '0; mat_b = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset result", result, '0);
        chk("reset busy", 256'(busy), 256'(0));
        chk("reset done", 256'(done), 256'(0));
        chk("reset overflow", 256'(overflow), 256'(0));
        @(negedge Clk);
        Reset = 1'b0;

        for (int v = 0; v < 5; v++)
            run_product(tv[v].name, tv[v].a, tv[v].b, tv[v].r, tv[v].ov);

        // Result holds while idle
        repeat (6) @(posedge Clk);
        #1;
        chk("hold_in_idle", result, tv[4].r);

        // Random products against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < 16; e++) begin
                if (r < 5) begin
                    ea[e] = 16'($signed(17'($urandom_range(0, 2047)) - 17'sd1024));
                    eb[e] = 16'($signed(17'($urandom_range(0, 2047)) - 17'sd1024));
                end else begin
                    ea[e] = 16'($urandom);
                    eb[e] = 16'($urandom);
                end
            end
            ref_mul(ea, eb, er, eov);
            run_product($sformatf("random%0d", r), ea, eb, er, eov);
        end

        // Start while busy: second request at E30 must be dropped
        ea = tv[1].a; eb = ident();
        do_start(ea, eb);
        run_to_done(29, m7f, m7f, lat, bok);
        chk("busy_start done_latency", 256'(lat), 256'(80));
        chk("busy_start result", result, tv[1].r);
        chk("busy_start overflow", 256'(overflow), 256'(0));
        extra_done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge Clk); #1;
            if (done || busy) extra_done = 1'b1;
        end
        chk("busy_start not_queued", 256'(extra_done), 256'(0));

        // Reset in the middle of an overflowing product
        do_start(m7f, m7f);
        repeat (40) @(posedge Clk);
        #1;
        chk("midreset overflow_before", 256'(overflow), 256'(1));
        Reset = 1'b1;
        #1;
        chk("midreset result", result, '0);
        chk("midreset busy", 256'(busy), 256'(0));
        chk("midreset done", 256'(done), 256'(0));
        chk("midreset overflow", 256'(overflow), 256'(0));
        extra_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge Clk); #1;
            if (done) extra_done = 1'b1;
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge Clk); #1;
            if (done || busy) extra_done = 1'b1;
        end
        chk("midreset no_done", 256'(extra_done), 256'(0));
        run_product("after_reset", tv[1].a, ident(), tv[1].r, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
